// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;
  localparam int          FETCH_XLEN = 32;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [31:0] PC_INC     = 32'd4;

  typedef enum logic [1:0] {FETCH, STALL, ERR} fetch_state_e;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
    logic                  err;
  } fetch_bundle_t;
endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding slot for a fetched bundle that decode could not take yet.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          flush,
  input  logic          drain,
  input  fetch_bundle_t din,
  output fetch_bundle_t dout,
  output logic          full
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full <= 1'b0;
      dout <= '0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      dout <= din;
    end else if (drain) begin
      full <= 1'b0;
    end
  end
endmodule

// File: rtl/pc_fetch_stage.sv
// Fetch stage: owns the PC, issues word fetches over req/ack and presents
// (pc, instr, err) to decode over valid/ready with a one-entry skid.
module pc_fetch_stage
  import fetch_pkg::*;
#(
  parameter int              XLEN      = FETCH_XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  output logic            out_err
);
  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] kill_addr;
  logic            kill;
  fetch_bundle_t   out_q;
  fetch_bundle_t   skid_q;
  logic            skid_full;
  logic            skid_load;
  logic            skid_drain;
  logic            out_fire;
  logic            out_free;

  // A killed request keeps its original address until the memory acks it.
  assign imem_req  = reset && (state == FETCH) && (kill || (pc[1:0] == 2'b00));
  assign imem_addr = kill ? kill_addr : pc;

  assign out_fire   = out_valid && out_ready;
  assign out_free   = !out_valid || out_ready;
  assign skid_load  = !redirect_valid && imem_req && imem_ack && !kill && !out_free;
  assign skid_drain = !redirect_valid && (state == STALL) && out_ready && skid_full;

  assign out_pc    = out_q.pc;
  assign out_instr = out_q.instr;
  assign out_err   = out_q.err;

  fetch_skid_buf u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load),
    .flush (redirect_valid),
    .drain (skid_drain),
    .din   ('{pc: pc, instr: imem_rdata, err: 1'b0}),
    .dout  (skid_q),
    .full  (skid_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      kill      <= 1'b0;
      kill_addr <= '0;
      out_valid <= 1'b0;
      out_q     <= '{pc: '0, instr: NOP_INSTR, err: 1'b0};
    end else begin
      if (out_fire) out_valid <= 1'b0;
      if (redirect_valid) begin
        pc        <= redirect_pc;
        state     <= FETCH;
        out_valid <= 1'b0;
        if (imem_req && !imem_ack) begin
          kill      <= 1'b1;
          kill_addr <= imem_addr;
        end else begin
          kill <= 1'b0;
        end
      end else begin
        case (state)
          FETCH: begin
            if (imem_req) begin
              if (imem_ack) begin
                if (kill) begin
                  kill <= 1'b0;
                end else begin
                  pc <= pc + PC_INC;
                  if (out_free) begin
                    out_q     <= '{pc: pc, instr: imem_rdata, err: 1'b0};
                    out_valid <= 1'b1;
                  end else begin
                    state <= STALL;
                  end
                end
              end
            end else if (out_free) begin
              // Misaligned PC: present a single faulting NOP bundle, then park.
              out_q     <= '{pc: pc, instr: NOP_INSTR, err: 1'b1};
              out_valid <= 1'b1;
              state     <= ERR;
            end
          end
          STALL: begin
            if (out_ready) begin
              out_q     <= skid_q;
              out_valid <= 1'b1;
              state     <= FETCH;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed vector bench for pc_fetch_stage: inputs applied after negedge,
// outputs compared 1ns later (before the next rising edge).
module tb_pc_fetch_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_err;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  pc_fetch_stage dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_err(out_err)
  );

  typedef struct {
    string       name;
    logic        rv;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] rdata;
    logic        rdy;
    logic        ereq;
    logic [31:0] eaddr;
    logic        eov;
    logic [31:0] epc;
    logic [31:0] einstr;
    logic        eerr;
  } vec_t;

  vec_t vecs[$];
  vec_t rvecs[$];

  function automatic vec_t mk(string n, logic rv, logic [31:0] rpc, logic ack,
                              logic [31:0] rdata, logic rdy, logic ereq,
                              logic [31:0] eaddr, logic eov, logic [31:0] epc,
                              logic [31:0] einstr, logic eerr);
    vec_t v;
    v.name = n; v.rv = rv; v.rpc = rpc; v.ack = ack; v.rdata = rdata; v.rdy = rdy;
    v.ereq = ereq; v.eaddr = eaddr; v.eov = eov; v.epc = epc; v.einstr = einstr;
    v.eerr = eerr;
    return v;
  endfunction

  // Address checked only while requesting; payload only while valid.
  task automatic check(input vec_t v);
    logic bad;
    bad = (imem_req !== v.ereq) || (out_valid !== v.eov);
    if (v.ereq && imem_addr !== v.eaddr) bad = 1'b1;
    if (v.eov && (out_pc !== v.epc || out_instr !== v.einstr || out_err !== v.eerr)) bad = 1'b1;
    nvec++;
    if (bad) begin
      nerr++;
      $display("FAIL %s: got req=%0b addr=%h ov=%0b pc=%h instr=%h err=%0b, want req=%0b addr=%h ov=%0b pc=%h instr=%h err=%0b",
               v.name, imem_req, imem_addr, out_valid, out_pc, out_instr, out_err,
               v.ereq, v.eaddr, v.eov, v.epc, v.einstr, v.eerr);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    imem_ack       = v.ack;
    imem_rdata     = v.rdata;
    out_ready      = v.rdy;
    #1;
    check(v);
  endtask

  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  initial begin
    //          name        rv rpc           ack rdata          rdy req addr          ov pc            instr          err
    vecs.push_back(mk("c0",      0, 0,            1, 32'h1000_0000, 1, 1, 32'h0,        0, 0,            0,             0));
    vecs.push_back(mk("c1",      0, 0,            1, 32'h1000_0004, 0, 1, 32'h4,        1, 32'h0,        32'h1000_0000, 0));
    vecs.push_back(mk("stall0",  0, 0,            0, 0,             0, 0, 0,            1, 32'h0,        32'h1000_0000, 0));
    vecs.push_back(mk("stall1",  0, 0,            0, 0,             0, 0, 0,            1, 32'h0,        32'h1000_0000, 0));
    vecs.push_back(mk("stall2",  0, 0,            0, 0,             1, 0, 0,            1, 32'h0,        32'h1000_0000, 0));
    vecs.push_back(mk("drain",   0, 0,            1, 32'h1000_0008, 1, 1, 32'h8,        1, 32'h4,        32'h1000_0004, 0));
    vecs.push_back(mk("pc8",     0, 0,            0, 0,             1, 1, 32'hC,        1, 32'h8,        32'h1000_0008, 0));
    vecs.push_back(mk("redir",   1, 32'h100,      0, 0,             1, 1, 32'hC,        0, 0,            0,             0));
    vecs.push_back(mk("killack", 0, 0,            1, JUNK,          1, 1, 32'hC,        0, 0,            0,             0));
    vecs.push_back(mk("tgt",     0, 0,            1, 32'h1000_0100, 1, 1, 32'h100,      0, 0,            0,             0));
    vecs.push_back(mk("tgtout",  0, 0,            0, 0,             1, 1, 32'h104,      1, 32'h100,      32'h1000_0100, 0));
    vecs.push_back(mk("redmis",  1, 32'h102,      1, JUNK,          1, 1, 32'h104,      0, 0,            0,             0));
    vecs.push_back(mk("mis0",    0, 0,            0, 0,             0, 0, 0,            0, 0,            0,             0));
    vecs.push_back(mk("err0",    0, 0,            0, 0,             0, 0, 0,            1, 32'h102,      NOP,           1));
    vecs.push_back(mk("err1",    0, 0,            0, 0,             1, 0, 0,            1, 32'h102,      NOP,           1));
    vecs.push_back(mk("errpark", 0, 0,            0, 0,             1, 0, 0,            0, 0,            0,             0));
    vecs.push_back(mk("red200",  1, 32'h200,      0, 0,             1, 0, 0,            0, 0,            0,             0));
    vecs.push_back(mk("f200",    0, 0,            1, 32'h1000_0200, 1, 1, 32'h200,      0, 0,            0,             0));
    vecs.push_back(mk("redtop",  1, 32'hFFFF_FFFC,0, 0,             1, 1, 32'h204,      1, 32'h200,      32'h1000_0200, 0));
    vecs.push_back(mk("kill204", 0, 0,            1, JUNK,          1, 1, 32'h204,      0, 0,            0,             0));
    vecs.push_back(mk("ftop",    0, 0,            1, 32'h1FFF_FFFC, 1, 1, 32'hFFFF_FFFC,0, 0,            0,             0));
    vecs.push_back(mk("wrap",    0, 0,            1, 32'h2000_0000, 1, 1, 32'h0,        1, 32'hFFFF_FFFC,32'h1FFF_FFFC, 0));
    vecs.push_back(mk("wrapout", 0, 0,            0, 0,             1, 1, 32'h4,        1, 32'h0,        32'h2000_0000, 0));
    vecs.push_back(mk("f4",      0, 0,            1, 32'h2000_0004, 0, 1, 32'h4,        0, 0,            0,             0));
    vecs.push_back(mk("toskid",  0, 0,            1, 32'h2000_0008, 0, 1, 32'h8,        1, 32'h4,        32'h2000_0004, 0));
    vecs.push_back(mk("skidful", 0, 0,            0, 0,             0, 0, 0,            1, 32'h4,        32'h2000_0004, 0));

    rvecs.push_back(mk("rst_f0", 0, 0,            1, 32'h3000_0000, 1, 1, 32'h0,        0, 0,            0,             0));
    rvecs.push_back(mk("rst_o0", 0, 0,            0, 0,             1, 1, 32'h4,        1, 32'h0,        32'h3000_0000, 0));
    rvecs.push_back(mk("rst_emp",0, 0,            0, 0,             1, 1, 32'h4,        0, 0,            0,             0));

    // Held in reset: request low and output at its reset values.
    @(negedge clk); #1;
    check(mk("reset", 0, 0, 0, 0, 0, 0, 0, 1'b0, 0, 0, 0));
    nvec++;
    if (out_pc !== 32'h0 || out_instr !== NOP || out_err !== 1'b0) begin
      nerr++;
      $display("FAIL reset_out: got pc=%h instr=%h err=%0b, want pc=0 instr=%h err=0",
               out_pc, out_instr, out_err, NOP);
    end
    @(posedge clk); #2 reset = 1'b1;

    foreach (vecs[i]) apply(vecs[i]);

    // Asynchronous reset in the middle of a stall with the skid full.
    @(negedge clk); #1;
    out_ready = 1'b0; imem_ack = 1'b0;
    reset = 1'b0;
    #1;
    check(mk("rst_async", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #2 reset = 1'b1;

    foreach (rvecs[i]) apply(rvecs[i]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
